skyline_profile: RTL

//  Receiving end of the skyline key-point stream produced by the skyline sketch engine.

---
 rtl/skyline_profile.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/skyline_profile.sv
// Skyline profile receiver: captures one burst of (x, y) key points and expands it
// into a dense per-column height profile, one column per cycle.
module skyline_profile #(
  parameter int W      = 6,
  parameter int MAX_X  = 30,
  parameter int MAX_KP = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         KP_VALID,
  input  logic [W-1:0] KP_DATA,
  output logic         H_VALID,
  output logic [W-1:0] H_X,
  output logic [W-1:0] H_DATA,
  output logic         DONE,
  output logic         ERR
);

  localparam int CW = $clog2(MAX_KP + 1);
  localparam int IW = $clog2(MAX_KP);

  typedef enum logic [1:0] {IDLE, CAPTURE, RENDER, FINISH} state_t;

  state_t         state;
  logic [W-1:0]   kp_x [MAX_KP];
  logic [W-1:0]   kp_y [MAX_KP];
  logic [CW-1:0]  kp_cnt;
  logic [CW-1:0]  rp;
  logic           parity;
  logic [W-1:0]   pend_x;
  logic [W-1:0]   last_x;
  logic [W-1:0]   last_y;
  logic [W-1:0]   rx;
  logic [W-1:0]   cur_h;
  logic           err;

  logic odd_word, x_in_order, x_in_range, has_room, store_ok, hit;

  // NOTE: every signal assigned in always_comb gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    odd_word   = (state == CAPTURE) && KP_VALID && parity;
    x_in_order = (kp_cnt == '0) || (pend_x > last_x);
    x_in_range = pend_x < W'(MAX_X);
    has_room   = kp_cnt < CW'(MAX_KP);
    store_ok   = odd_word && x_in_order && x_in_range && has_room;
    hit        = (rp < kp_cnt) && (kp_x[rp[IW-1:0]] == rx);
  end

  // NOTE: the key-point storage is deliberately not reset; kp_cnt alone marks which entries are live.
  always_ff @(posedge CLK) begin
    if (store_ok) begin
      kp_x[kp_cnt[IW-1:0]] <= pend_x;
      kp_y[kp_cnt[IW-1:0]] <= KP_DATA;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      H_VALID <= 1'b0;
      H_X     <= '0;
      H_DATA  <= '0;
      DONE    <= 1'b0;
      err     <= 1'b0;
      kp_cnt  <= '0;
      rp      <= '0;
      parity  <= 1'b0;
      pend_x  <= '0;
      last_x  <= '0;
      last_y  <= '0;
      rx      <= '0;
      cur_h   <= '0;
    end else begin
      case (state)
        IDLE: begin
          DONE   <= 1'b0;
          err    <= 1'b0;
          kp_cnt <= '0;
          parity <= 1'b0;
          if (KP_VALID) begin
            pend_x <= KP_DATA;
            parity <= 1'b1;
            state  <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (KP_VALID) begin
            parity <= ~parity;
            if (!parity) begin
              pend_x <= KP_DATA;
            end else if (store_ok) begin
              kp_cnt <= kp_cnt + CW'(1);
              last_x <= pend_x;
              last_y <= KP_DATA;
            end else begin
              err <= 1'b1;
            end
          end else begin
            // End of burst: a dangling x or an unclosed profile are both errors.
            if (parity || ((kp_cnt != '0) && (last_y != '0)))
              err <= 1'b1;
            parity <= 1'b0;
            rx     <= '0;
            rp     <= '0;
            cur_h  <= '0;
            state  <= RENDER;
          end
        end

        RENDER: begin
          H_VALID <= 1'b1;
          H_X     <= rx;
          if (hit) begin
            H_DATA <= kp_y[rp[IW-1:0]];
            cur_h  <= kp_y[rp[IW-1:0]];
            rp     <= rp + CW'(1);
          end else begin
            H_DATA <= cur_h;
          end
          if (KP_VALID)
            err <= 1'b1;
          if (rx == W'(MAX_X - 1))
            state <= FINISH;
          else
            rx <= rx + W'(1);
        end

        FINISH: begin
          H_VALID <= 1'b0;
          DONE    <= 1'b1;
          if (KP_VALID)
            err <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign ERR = err;

endmodule
